dlx_fetch_queue: RTL

Instruction fetch unit between `ROM_BLOCK` and the `dlxpipeline` decode stage. It owns the fetch PC and issues sequential word addresses to the one-cycle-latency ROM. Returned instructions are buffered, each tagged with its PC, in a small FIFO so decode can stall without losing fetch bandwidth. A taken branch or jump flushes the FIFO and discards the in-flight fetch.

---
 rtl/dlx_pkg.sv | 14 +
 rtl/dlx_fetch_fifo.sv | 69 ++++++
 rtl/dlx_fetch_queue.sv | 87 ++++++++
 3 files changed

// File: rtl/dlx_pkg.sv
// Shared DLX definitions: datapath width, instruction size and the fetch-queue entry layout.
package dlx_pkg;

  localparam int unsigned XLEN       = 32;
  localparam int unsigned INST_BYTES = 4;

  localparam logic [XLEN-1:0] NOP_INST = 32'h0000_0000;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inst;
  } fetch_entry_t;

endpackage

// File: rtl/dlx_fetch_fifo.sv
// Circular buffer of fetched {pc, inst} entries; flush beats push and pop.
module dlx_fetch_fifo
  import dlx_pkg::*;
#(
  parameter  int unsigned DEPTH = 4,
  localparam int unsigned AW    = $clog2(DEPTH),
  localparam int unsigned CW    = AW + 1
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          push_i,
  input  fetch_entry_t  entry_i,
  input  logic          pop_i,
  input  logic          flush_i,
  output fetch_entry_t  head_o,
  output logic [CW-1:0] count_o
);

  fetch_entry_t  mem_q [DEPTH];
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          pop_ok, push_ok;

  assign pop_ok  = pop_i && (count_q != '0);
  assign push_ok = push_i && ((count_q < CW'(DEPTH)) || pop_ok);

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
      if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
      unique case ({push_ok, pop_ok})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is deliberately left unreset; count gates every read of it.
  always_ff @(posedge clock) begin
    if (push_ok && !flush_i) begin
      mem_q[wr_ptr_q] <= entry_i;
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/dlx_fetch_queue.sv
// Fetch unit: owns the fetch PC, issues to a 1-cycle ROM and queues {pc, inst} for decode.
module dlx_fetch_queue
  import dlx_pkg::*;
#(
  parameter  int unsigned     DEPTH    = 4,
  parameter  logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
  localparam int unsigned     CW       = $clog2(DEPTH) + 1
) (
  input  logic            clock,
  input  logic            reset,
  output logic [XLEN-1:0] rom_addr,
  input  logic [XLEN-1:0] rom_data,
  input  logic            redirect_en,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            stall,
  output logic            inst_valid,
  output logic [XLEN-1:0] inst_out,
  output logic [XLEN-1:0] inst_pc,
  output logic [XLEN-1:0] inst_npc,
  output logic [CW-1:0]   count
);

  logic [XLEN-1:0] fpc_q, fpc_d;
  logic            inflight_q, inflight_d;
  logic [XLEN-1:0] inflight_pc_q, inflight_pc_d;

  logic [CW-1:0]   fifo_count;
  logic [CW:0]     occupancy;
  logic            issue, push, pop;
  fetch_entry_t    head;
  fetch_entry_t    new_entry;

  // Counting the in-flight fetch reserves its slot, so a write can never overflow.
  assign occupancy = {1'b0, fifo_count} + (CW + 1)'(inflight_q);
  assign issue     = !redirect_en && (occupancy < (CW + 1)'(DEPTH));
  assign push      = inflight_q && !redirect_en;
  assign pop       = inst_valid && !stall && !redirect_en;

  assign new_entry.pc   = inflight_pc_q;
  assign new_entry.inst = rom_data;

  always_comb begin
    fpc_d         = fpc_q;
    inflight_d    = 1'b0;
    inflight_pc_d = inflight_pc_q;
    if (redirect_en) begin
      fpc_d = redirect_pc & ~XLEN'(INST_BYTES - 1);
    end else if (issue) begin
      inflight_d    = 1'b1;
      inflight_pc_d = fpc_q;
      fpc_d         = fpc_q + XLEN'(INST_BYTES);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      fpc_q         <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
    end else begin
      fpc_q         <= fpc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
    end
  end

  dlx_fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock   (clock),
    .reset   (reset),
    .push_i  (push),
    .entry_i (new_entry),
    .pop_i   (pop),
    .flush_i (redirect_en),
    .head_o  (head),
    .count_o (fifo_count)
  );

  assign rom_addr   = fpc_q;
  assign count      = fifo_count;
  assign inst_valid = (fifo_count != '0);
  assign inst_out   = inst_valid ? head.inst : NOP_INST;
  assign inst_pc    = inst_valid ? head.pc : '0;
  assign inst_npc   = inst_valid ? (head.pc + XLEN'(INST_BYTES)) : '0;

endmodule
